kernel_mem_loader: RTL and testbench

- Upstream write-side controller for the two-block ping-pong kernel memory (2 blocks x 2 sub-blocks, 512 entries, 16 complex per entry).
- Accepts one cacheline per beat (8 complex) over a valid/ready stream.
- Writes each cacheline pair as one kernel entry: even beat to sub-block 0, odd beat to sub-block 1.
- Publishes per-block full flags to the downstream FFT/multiply stage and frees each block when that stage releases it.

---
 rtl/kernel_mem_loader_if.sv | 34 +++
 rtl/kernel_mem_loader.sv | 114 +++++++++++
 tb/tb_kernel_mem_loader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/kernel_mem_loader_if.sv
// Shared complex sample type and the stream-in / memory-write bundle of the kernel loader.
package kernel_mem_loader_pkg;
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_t;
endpackage

interface kernel_mem_loader_if
    import kernel_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
);
    logic                    in_valid;
    logic                    in_ready;
    complex_t [0:1][0:3]     in_data;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_write_address;
    logic                    mem_select_block_we;
    logic                    mem_select_sub_block_we;
    complex_t [0:1][0:3]     mem_in;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_write_address,
               mem_select_block_we, mem_select_sub_block_we, mem_in
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_write_address,
               mem_select_block_we, mem_select_sub_block_we, mem_in
    );
endinterface

// File: rtl/kernel_mem_loader.sv
// Write-side controller for the ping-pong kernel memory: two cachelines per entry, per-block full flags.
// Optional sticky protocol-error output enabled by defining KERNEL_LOADER_ERR_EN.
module kernel_mem_loader
    import kernel_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_entries,
    kernel_mem_loader_if.slave    bus,
    output logic [1:0]            block_full,
    input  logic [1:0]            block_release,
    output logic                  busy,
    output logic                  load_done
`ifdef KERNEL_LOADER_ERR_EN
    ,
    output logic                  err_unexpected
`endif
);

    // state    | meaning
    // IDLE     | waiting for start
    // WAIT_BLK | target block still held by the consumer
    // LOAD_LO  | expecting the even beat (sub-block 0)
    // LOAD_HI  | expecting the odd beat (sub-block 1)
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_BLK = 2'd1;
    localparam logic [1:0] S_LOAD_LO  = 2'd2;
    localparam logic [1:0] S_LOAD_HI  = 2'd3;

    logic [1:0]            state;
    logic                  ptr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  accept;
    logic                  last_beat;
    logic [1:0]            set_mask;

    assign bus.in_ready = (state == S_LOAD_LO) || (state == S_LOAD_HI);
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_beat    = accept && (state == S_LOAD_HI) && (addr == last_addr);
    assign set_mask     = {last_beat && ptr, last_beat && !ptr};
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                       <= S_IDLE;
            ptr                         <= 1'b0;
            addr                        <= '0;
            last_addr                   <= '0;
            block_full                  <= 2'b00;
            load_done                   <= 1'b0;
            bus.mem_we                  <= 1'b0;
            bus.mem_write_address       <= '0;
            bus.mem_select_block_we     <= 1'b0;
            bus.mem_select_sub_block_we <= 1'b0;
            bus.mem_in                  <= '0;
        end else begin
            bus.mem_we <= accept;
            if (accept) begin
                bus.mem_write_address       <= addr;
                bus.mem_select_block_we     <= ptr;
                bus.mem_select_sub_block_we <= (state == S_LOAD_HI);
                bus.mem_in                  <= bus.in_data;
            end
            load_done  <= last_beat;
            // set is applied after release so a coincident set wins
            block_full <= (block_full & ~block_release) | set_mask;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        // 0 wraps to all ones, i.e. a full-depth load
                        last_addr <= num_entries - ADDR_WIDTH'(1);
                        state     <= S_WAIT_BLK;
                    end
                end
                S_WAIT_BLK: begin
                    if (!block_full[ptr] || block_release[ptr]) begin
                        addr  <= '0;
                        state <= S_LOAD_LO;
                    end
                end
                S_LOAD_LO: begin
                    if (accept) state <= S_LOAD_HI;
                end
                default: begin
                    if (accept) begin
                        if (last_beat) begin
                            ptr   <= ~ptr;
                            state <= S_IDLE;
                        end else begin
                            addr  <= addr + ADDR_WIDTH'(1);
                            state <= S_LOAD_LO;
                        end
                    end
                end
            endcase
        end
    end

`ifdef KERNEL_LOADER_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_unexpected <= 1'b0;
        end else if ((bus.in_valid && !bus.in_ready) || (start && busy)) begin
            err_unexpected <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_kernel_mem_loader.sv
// Directed bench for kernel_mem_loader; define KERNEL_LOADER_ERR_EN to also exercise err_unexpected.
module tb_kernel_mem_loader;
    import kernel_mem_loader_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] num_entries;
    logic [1:0] block_full;
    logic [1:0] block_release;
    logic       busy;
    logic       load_done;
`ifdef KERNEL_LOADER_ERR_EN
    logic       err_unexpected;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    kernel_mem_loader_if #(.ADDR_WIDTH(9)) bus ();

    kernel_mem_loader #(.ADDR_WIDTH(9)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_entries   (num_entries),
        .bus           (bus.slave),
        .block_full    (block_full),
        .block_release (block_release),
        .busy          (busy),
        .load_done     (load_done)
`ifdef KERNEL_LOADER_ERR_EN
        ,
        .err_unexpected(err_unexpected)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_data(input int tag, input int b);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = {16'(tag), 16'(b * 8 + k)};
        return d;
    endfunction

    task automatic start_load(input int n);
        @(negedge clk);
        start       = 1'b1;
        num_entries = 9'(n);
        @(negedge clk);
        start = 1'b0;
        chk("wait_busy", busy, 1);
        chk("wait_in_ready", bus.in_ready, 0);
        chk("wait_mem_we", bus.mem_we, 0);
    endtask

    // drives 2*n beats from the first LOAD_LO cycle and checks every write one cycle after its accept
    task automatic do_load(input int n, input bit blk, input bit gaps, input int tag);
        int           beats;
        int           sent;
        int           cyc;
        int           prev_beat;
        bit           acc_prev;
        logic [255:0] prev_d;
        beats = 2 * n; sent = 0; cyc = 0; prev_beat = 0; acc_prev = 0; prev_d = '0;
        while (sent < beats || acc_prev) begin
            @(negedge clk);
            block_release = 2'b00;
            chk("mem_we", bus.mem_we, acc_prev);
            if (acc_prev) begin
                chk("addr", bus.mem_write_address, prev_beat / 2);
                chk("sub", bus.mem_select_sub_block_we, prev_beat % 2);
                chk("blk", bus.mem_select_block_we, blk);
                chk("mem_in", bus.mem_in, prev_d);
                chk("load_done", load_done, prev_beat == beats - 1);
            end else begin
                chk("load_done_idle", load_done, 0);
            end
            acc_prev = 0;
            if (sent < beats) begin
                chk("in_ready", bus.in_ready, 1);
                bus.in_data = mk_data(tag, sent);
                if (!gaps || (cyc % 3) != 1) begin
                    bus.in_valid = 1'b1;
                    acc_prev     = 1;
                    prev_d       = mk_data(tag, sent);
                    prev_beat    = sent;
                    sent++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            cyc++;
            if (cyc > 4 * beats + 16) begin
                chk("load_timeout", 1, 0);
                break;
            end
        end
        bus.in_valid = 1'b0;
        chk("done_busy", busy, 0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        num_entries   = '0;
        block_release = 2'b00;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_block_full", block_full, 2'b00);
        chk("rst_load_done", load_done, 0);
        chk("rst_addr", bus.mem_write_address, 0);
        chk("rst_blk", bus.mem_select_block_we, 0);
        chk("rst_sub", bus.mem_select_sub_block_we, 0);
        chk("rst_mem_in", bus.mem_in, 0);
`ifdef KERNEL_LOADER_ERR_EN
        chk("rst_err", err_unexpected, 0);
`endif
        reset = 1'b0;

`ifdef KERNEL_LOADER_ERR_EN
        @(negedge clk);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("err_idle_valid", err_unexpected, 1);
`endif

        // single entry into block 0
        start_load(1);
        do_load(1, 1'b0, 1'b0, 1);
        chk("t1_block_full", block_full, 2'b01);
`ifdef KERNEL_LOADER_ERR_EN
        chk("err_sticky_1", err_unexpected, 1);
`endif

        // full-depth load lands in block 1 since the pointer toggled
        start_load(0);
        do_load(512, 1'b1, 1'b0, 2);
        chk("t2_block_full", block_full, 2'b11);
        @(negedge clk);
        chk("t2_load_done_low", load_done, 0);
        block_release = 2'b11;
        @(negedge clk);
        block_release = 2'b00;
        chk("t2_released", block_full, 2'b00);

        // fill both blocks, then a third load must stall until block 0 is released
        start_load(4);
        do_load(4, 1'b0, 1'b0, 3);
        start_load(4);
        do_load(4, 1'b1, 1'b0, 4);
        chk("t3_both_full", block_full, 2'b11);
        start_load(8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_busy", busy, 1);
            chk("stall_mem_we", bus.mem_we, 0);
        end
        block_release = 2'b01;
        do_load(8, 1'b0, 1'b1, 5);
        chk("t3_refilled", block_full, 2'b11);
`ifdef KERNEL_LOADER_ERR_EN
        chk("err_sticky_2", err_unexpected, 1);
`endif

        // reset three beats into a 4-entry load of block 1
        @(negedge clk);
        block_release = 2'b10;
        @(negedge clk);
        block_release = 2'b00;
        chk("t5_pre_full", block_full, 2'b01);
        start_load(4);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            chk("t5_in_ready", bus.in_ready, 1);
            bus.in_valid = 1'b1;
            bus.in_data  = mk_data(6, b);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t5_pre_we", bus.mem_we, 1);
        reset = 1'b1;
        #1;
        chk("t5_rst_we", bus.mem_we, 0);
        chk("t5_rst_full", block_full, 2'b00);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_in_ready", bus.in_ready, 0);
        chk("t5_rst_addr", bus.mem_write_address, 0);
        chk("t5_rst_done", load_done, 0);
        chk("t5_rst_mem_in", bus.mem_in, 0);
        @(negedge clk);
        reset = 1'b0;
        start_load(1);
        do_load(1, 1'b0, 1'b0, 7);
        chk("t5_after_full", block_full, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
